noc_adder_sequencer: RTL
========================

Name: noc_adder_sequencer

Overview:
- Hardware replacement for the bench-driven injection loop around noc_adder_top.
- Issues N operand-injection transactions as a START pulse then a START2 pulse, and waits for the adder's DONE rising edge.
- Captures DATA_O into a ready/valid result port and counts completed packets.
- Sits on the CLK (host) side next to noc_adder_top; CLK_NOC remains the adder's own concern.

Parameters:
- TDATAW, pkg value, result data width; matches adder DATA_O.
- PKTW, 16, width of packet-count fields.
- GAP_CYC, 2, idle cycles between result accept and next START (min 0).
- TIMEOUT_CYC, 1024, WAIT_DONE watchdog limit (used only with TIMEOUT_EN).

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  one-cycle start-of-batch request.
- NUM_PKT  in  PKTW  packet count; sampled with RUN.
- DONE  in  1  adder completion (level); block uses its rising edge.
- DATA_I  in  TDATAW  adder DATA_O.
- START  out  1  adder START pulse.
- START2  out  1  adder START2 pulse.
- RESULT_VALID  out  1  captured result valid.
- RESULT_DATA  out  TDATAW  captured result.
- RESULT_READY  in  1  consumer accept.
- BUSY  out  1  batch in progress.
- PKT_CNT  out  PKTW  results accepted in current/last batch.
- FINISHED  out  1  one-cycle end-of-batch pulse.
- ERR_TIMEOUT  out  1  sticky watchdog flag.

Behaviour:
- Reset (async assert, sync deassert by design above): state IDLE; all outputs 0; done_q=0; counters 0.
- All outputs are registered.
- done_rise = DONE & ~done_q. done_q updates every cycle in every state.
- FSM states:
  - IDLE: on RUN, latch NUM_PKT, clear PKT_CNT and ERR_TIMEOUT, set BUSY. If NUM_PKT==0 go FINISH, else ISSUE1. RUN is ignored in all other states.
  - ISSUE1: START=1 for exactly this cycle → ISSUE2.
  - ISSUE2: START2=1 for exactly this cycle → WAIT_DONE.
  - WAIT_DONE: on done_rise, register DATA_I into RESULT_DATA, set RESULT_VALID → HOLD. done_rise in ISSUE1/ISSUE2 is ignored (stale).
  - HOLD: RESULT_VALID and RESULT_DATA stable until RESULT_VALID&RESULT_READY. On that cycle: clear valid, PKT_CNT+1. If PKT_CNT+1==latched N go FINISH, else GAP (or ISSUE1 directly if GAP_CYC==0).
  - GAP: count GAP_CYC cycles → ISSUE1.
  - FINISH: FINISHED=1 for one cycle, BUSY=0 → IDLE.
- Latency: RUN at cycle 0 → START at cycle 1, START2 at cycle 2. done_rise at cycle t → RESULT_VALID at t+1. READY at the same cycle as VALID is accepted in that cycle.
- PKT_CNT holds its value after FINISH until the next RUN. Increments are gated by NUM_PKT, so there is no wrap.
- RST mid-batch: immediate return to IDLE, outputs 0, in-flight result discarded.
- NUM_PKT max (2^PKTW-1) must complete exactly that many packets.

Optional Feature:
- Macro: NOC_SEQ_TIMEOUT_EN.
- Defined: a WAIT_DONE cycle counter is active. Reaching TIMEOUT_CYC without done_rise sets ERR_TIMEOUT (sticky until next RUN or reset) and goes to FINISH without incrementing PKT_CNT, aborting the batch.
- Undefined: no counter; WAIT_DONE waits indefinitely; ERR_TIMEOUT tied 0.

Decomposition:
- Shared package, alongside existing parameters: state enum seq_state_t (IDLE, ISSUE1, ISSUE2, WAIT_DONE, HOLD, GAP, FINISH); TDATAW is imported from there.
- One natural sub-module: noc_seq_edge_det (1-bit registered rising-edge detector with async active-high reset). All else stays in noc_adder_sequencer.

Test Plan:
- RUN with NUM_PKT=3, stub adder raises DONE 5 cycles after START2 with DATA_I=0xA5, 0xB6, 0xC7, RESULT_READY=1 → three START/START2 pulse pairs spaced per GAP_CYC=2; results 0xA5, 0xB6, 0xC7 in order; PKT_CNT=3; one FINISHED pulse; BUSY low after.
- NUM_PKT=0 → no START/START2; FINISHED pulses 2 cycles after RUN; PKT_CNT=0.
- Backpressure: RESULT_READY held 0 for 10 cycles → RESULT_VALID/RESULT_DATA stable; no new START until accept; PKT_CNT increments exactly once.
- DONE stuck high from prior packet → no spurious capture; capture only after DONE drops and rises again.
- RST asserted during WAIT_DONE of packet 2 of 4 → all outputs 0 immediately. New RUN with NUM_PKT=1 runs cleanly, giving PKT_CNT=1.
- NOC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, DONE never rises → ERR_TIMEOUT=1 and FINISHED at cycle 16 of WAIT_DONE, PKT_CNT=0. Next RUN clears ERR_TIMEOUT.

Source files
------------

// File: rtl/noc_adder_sequencer_pkg.sv
// rtl/noc_adder_sequencer_pkg.sv - shared widths and state encoding for the adder sequencer
package noc_adder_sequencer_pkg;

    // Result data width; matches the adder DATA_O bus
    localparam int TDATAW = 32;

    // Sequencer control states
    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        ISSUE2,
        WAIT_DONE,
        HOLD,
        GAP,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/noc_seq_edge_det.sv
// rtl/noc_seq_edge_det.sv - registered rising-edge detector for the adder DONE level
module noc_seq_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous-cycle copy of the input; cleared on reset so a level already high
    // when reset releases is reported as a fresh edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/noc_adder_sequencer.sv
// rtl/noc_adder_sequencer.sv - START/START2 injection sequencer with result capture; optional watchdog under NOC_SEQ_TIMEOUT_EN
module noc_adder_sequencer
    import noc_adder_sequencer_pkg::*;
#(
    parameter int PKTW        = 16,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [PKTW-1:0]   NUM_PKT,
    input  logic              DONE,
    input  logic [TDATAW-1:0] DATA_I,
    output logic              START,
    output logic              START2,
    output logic              RESULT_VALID,
    output logic [TDATAW-1:0] RESULT_DATA,
    input  logic              RESULT_READY,
    output logic              BUSY,
    output logic [PKTW-1:0]   PKT_CNT,
    output logic              FINISHED,
    output logic              ERR_TIMEOUT
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    seq_state_t          state;
    logic [PKTW-1:0]     num_q;
    logic [GAP_W-1:0]    gap_cnt;
    logic [PKTW-1:0]     cnt_inc;
    logic                done_rise;

    assign cnt_inc = PKT_CNT + PKTW'(1);

    noc_seq_edge_det u_done_edge (
        .clk  (CLK),
        .rst  (RST),
        .d    (DONE),
        .rise (done_rise)
    );

`ifdef NOC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign ERR_TIMEOUT        = 1'b0;
`endif

    // Batch control FSM; every output is registered and START/START2/FINISHED
    // default low so each is a single-cycle pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            START        <= 1'b0;
            START2       <= 1'b0;
            RESULT_VALID <= 1'b0;
            RESULT_DATA  <= '0;
            BUSY         <= 1'b0;
            PKT_CNT      <= '0;
            FINISHED     <= 1'b0;
            num_q        <= '0;
            gap_cnt      <= '0;
`ifdef NOC_SEQ_TIMEOUT_EN
            ERR_TIMEOUT  <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            START    <= 1'b0;
            START2   <= 1'b0;
            FINISHED <= 1'b0;
            case (state)
                IDLE: begin
                    if (RUN) begin
                        num_q   <= NUM_PKT;
                        PKT_CNT <= '0;
                        BUSY    <= 1'b1;
`ifdef NOC_SEQ_TIMEOUT_EN
                        ERR_TIMEOUT <= 1'b0;
`endif
                        if (NUM_PKT == '0) begin
                            state <= FINISH;
                        end else begin
                            state <= ISSUE1;
                            START <= 1'b1;
                        end
                    end
                end
                ISSUE1: begin
                    START2 <= 1'b1;
                    state  <= ISSUE2;
                end
                ISSUE2: begin
                    // Any DONE edge seen before this point belongs to an older
                    // packet; the detector has already consumed it
                    state <= WAIT_DONE;
`ifdef NOC_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        RESULT_DATA  <= DATA_I;
                        RESULT_VALID <= 1'b1;
                        state        <= HOLD;
`ifdef NOC_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
`endif
                    end
                end
                HOLD: begin
                    if (RESULT_VALID && RESULT_READY) begin
                        RESULT_VALID <= 1'b0;
                        PKT_CNT      <= cnt_inc;
                        if (cnt_inc == num_q) begin
                            state <= FINISH;
                        end else if (GAP_CYC == 0) begin
                            state <= ISSUE1;
                            START <= 1'b1;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= ISSUE1;
                        START <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                FINISH: begin
                    FINISHED <= 1'b1;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
